// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pc_seq_pkg                                                    |
// | Brief  : Shared types for the fetch-stage program-counter sequencer:   |
// |          FSM state encoding, next-PC select codes, LUT index width.    |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package pc_seq_pkg;

  localparam int LUT_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Source of the next program-counter value.
  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_INC   = 3'd1,
    SEL_BR    = 3'd2,
    SEL_RET   = 3'd3,
    SEL_START = 3'd4
  } pc_sel_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pc_seq_if                                                     |
// | Brief  : Control/LUT/status bundle between decoder, branch-target LUT  |
// |          and the PC sequencer.                                         |
// |   slave  : sequencer view (controls + lut_target in, status out)       |
// |   master : decoder/LUT view (opposite directions)                      |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
interface pc_seq_if
  import pc_seq_pkg::*;
#(
  parameter int D = 10
);
  logic                 start;
  logic                 stall;
  logic                 branch_en;
  logic                 abs_jump;
  logic                 call;
  logic                 ret;
  logic [LUT_IDX_W-1:0] lut_idx;
  logic                 halt_req;
  logic [LUT_IDX_W-1:0] lut_addr;
  logic [D-1:0]         lut_target;
  logic [D-1:0]         prog_ctr;
  logic                 running;
  logic                 done;
  logic                 stack_err;

  modport slave (
    input  start, stall, branch_en, abs_jump, call, ret, lut_idx, halt_req, lut_target,
    output lut_addr, prog_ctr, running, done, stack_err
  );

  modport master (
    output start, stall, branch_en, abs_jump, call, ret, lut_idx, halt_req, lut_target,
    input  lut_addr, prog_ctr, running, done, stack_err
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer_ret_stack.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pc_ret_stack                                                  |
// | Brief  : LIFO of return addresses. push_i when full and pop_i when     |
// |          empty are ignored; the parent flags those cases.              |
// |   clk, reset       : clock, synchronous active-high reset (empties)    |
// |   push_i, din_i    : push din_i                                        |
// |   pop_i, dout_o    : dout_o is the current top-of-stack                |
// |   full_o, empty_o  : occupancy flags                                   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int D           = 10,
  parameter int STACK_DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         push_i,
  input  wire logic         pop_i,
  input  wire logic [D-1:0] din_i,
  output logic      [D-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [D-1:0]   mem_q [STACK_DEPTH];
  logic [PTR_W:0] cnt_q;
  logic [PTR_W-1:0] top_idx;

  assign full_o  = (cnt_q == (PTR_W+1)'(STACK_DEPTH));
  assign empty_o = (cnt_q == '0);
  // Top entry sits one below the fill count.
  assign top_idx = cnt_q[PTR_W-1:0] - PTR_W'(1);
  assign dout_o  = mem_q[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (push_i && !full_o) begin
      mem_q[cnt_q[PTR_W-1:0]] <= din_i;
      cnt_q <= cnt_q + (PTR_W+1)'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pc_sequencer                                                  |
// | Brief  : Fetch-stage program counter: +1 per cycle, LUT-driven         |
// |          absolute/relative branches, stall, halt, restart.             |
// |   clk, reset : clock, synchronous active-high reset                    |
// |   bus        : pc_seq_if.slave (controls, LUT index/target, status)    |
// | Option : PC_CALL_STACK_EN - adds call/ret return stack and stack_err   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D           = 10,
  parameter int START_ADDR  = 0,
  parameter int STACK_DEPTH = 4
) (
  input wire logic clk,
  input wire logic reset,
  pc_seq_if.slave  bus
);
  localparam logic [D-1:0] START_PC = D'(START_ADDR);

  pc_state_t    state_q, state_d;
  pc_sel_t      sel;
  logic [D-1:0] pc_q, pc_d;
  logic         done_q;

`ifdef PC_CALL_STACK_EN
  logic         push, pop, err_set, err_q;
  logic         stk_full, stk_empty;
  logic [D-1:0] stk_dout;

  pc_ret_stack #(.D(D), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_q + D'(1)),
    .dout_o  (stk_dout),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );
`else
  // ret has no effect without the return stack.
  logic unused_ret;
  assign unused_ret = bus.ret;
`endif

  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
`ifdef PC_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
`endif
    case (state_q)
      IDLE, HALT: begin
        if (bus.start) begin
          state_d = RUN;
          sel     = SEL_START;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d = HALT;
        end else if (bus.stall) begin
          sel = SEL_HOLD;
`ifdef PC_CALL_STACK_EN
        end else if (bus.ret) begin
          // Return on an empty stack falls through to a plain increment.
          if (stk_empty) begin
            sel     = SEL_INC;
            err_set = 1'b1;
          end else begin
            sel = SEL_RET;
            pop = 1'b1;
          end
        end else if (bus.branch_en || bus.call) begin
          sel = SEL_BR;
          if (bus.call) begin
            if (stk_full) err_set = 1'b1;
            else          push    = 1'b1;
          end
`else
        end else if (bus.branch_en || bus.call) begin
          sel = SEL_BR;
`endif
        end else begin
          sel = SEL_INC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_INC:   pc_d = pc_q + D'(1);
      SEL_BR:    pc_d = bus.abs_jump ? bus.lut_target : (pc_q + bus.lut_target);
`ifdef PC_CALL_STACK_EN
      SEL_RET:   pc_d = stk_dout;
`endif
      SEL_START: pc_d = START_PC;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= (state_d == HALT);
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge clk) begin
    if (reset)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign bus.stack_err = err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  assign bus.lut_addr = bus.lut_idx;
  assign bus.prog_ctr = pc_q;
  assign bus.running  = (state_q == RUN);
  assign bus.done     = done_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_pc_sequencer                                               |
// | Brief  : Directed bench for pc_sequencer with expected-value queue and |
// |          an independent monitor. Honors PC_CALL_STACK_EN.             |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int D = 10;

  // Control word bit positions: {start, stall, branch_en, abs_jump, call, ret, halt_req}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_ST   = 7'b1000000;
  localparam logic [6:0] C_SL   = 7'b0100000;
  localparam logic [6:0] C_BR   = 7'b0010000;
  localparam logic [6:0] C_AB   = 7'b0001000;
  localparam logic [6:0] C_CL   = 7'b0000100;
  localparam logic [6:0] C_RT   = 7'b0000010;
  localparam logic [6:0] C_HL   = 7'b0000001;

  typedef struct {
    logic [D-1:0] pc;
    logic         run;
    logic         dn;
    logic         err;
    logic [3:0]   idx;
    string        name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  pc_seq_if #(.D(D)) bus ();

  pc_sequencer #(.D(D), .START_ADDR(0), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Branch-target LUT model.
  function automatic logic [D-1:0] lut(input logic [3:0] a);
    case (a)
      4'd0:    lut = 10'd0;
      4'd1:    lut = 10'd10;
      4'd2:    lut = 10'd43;
      4'd3:    lut = 10'd20;
      4'd4:    lut = 10'd1023;
      4'd5:    lut = 10'd1020;
      4'd6:    lut = 10'd7;
      4'd7:    lut = 10'd5;
      4'd9:    lut = 10'h3FB;
      default: lut = 10'd0;
    endcase
  endfunction
  assign bus.lut_target = lut(bus.lut_addr);

  task automatic step(input string nm, input logic [6:0] c, input logic [3:0] idx,
                      input logic [D-1:0] epc, input logic er, input logic ed,
                      input logic ee);
    exp_t e;
    @(negedge clk);
    {bus.start, bus.stall, bus.branch_en, bus.abs_jump, bus.call, bus.ret, bus.halt_req} = c;
    bus.lut_idx = idx;
    e.pc = epc; e.run = er; e.dn = ed; e.err = ee; e.idx = idx; e.name = nm;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_reset(input string nm);
    exp_t e;
    @(negedge clk);
    reset = 1'b1;
    e.pc = '0; e.run = 1'b0; e.dn = 1'b0; e.err = 1'b0; e.idx = bus.lut_idx; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: each expectation belongs to the edge that directly follows its push.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (bus.prog_ctr !== e.pc || bus.running !== e.run || bus.done !== e.dn ||
          bus.stack_err !== e.err || bus.lut_addr !== e.idx) begin
        n_bad++;
        $display("FAIL %s: got pc=%0d run=%b done=%b err=%b lut_addr=%0d, want pc=%0d run=%b done=%b err=%b lut_addr=%0d",
                 e.name, bus.prog_ctr, bus.running, bus.done, bus.stack_err, bus.lut_addr,
                 e.pc, e.run, e.dn, e.err, e.idx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    {bus.start, bus.stall, bus.branch_en, bus.abs_jump, bus.call, bus.ret, bus.halt_req} = '0;
    bus.lut_idx = '0;

    // 1. reset, start, increment
    do_reset("reset");
    step("idle_hold", C_BR | C_AB, 4'd2, 10'd0, 0, 0, 0);
    step("start",     C_ST,        4'd0, 10'd0, 1, 0, 0);
    for (int i = 1; i <= 5; i++)
      step("inc", C_NONE, 4'd0, D'(i), 1, 0, 0);

    // 2. absolute and relative branches
    step("abs_to_20",  C_BR | C_AB, 4'd3, 10'd20, 1, 0, 0);
    step("rel_minus5", C_BR,        4'd9, 10'd15, 1, 0, 0);
    step("abs_43",     C_BR | C_AB, 4'd2, 10'd43, 1, 0, 0);

    // 3. wrap-around
    step("abs_1023",   C_BR | C_AB, 4'd4, 10'd1023, 1, 0, 0);
    step("inc_wrap",   C_NONE,      4'd0, 10'd0,    1, 0, 0);
    step("abs_1020",   C_BR | C_AB, 4'd5, 10'd1020, 1, 0, 0);
    step("rel_wrap",   C_BR,        4'd1, 10'd6,    1, 0, 0);

    // 4. stall, halt, restart
    step("abs_7",      C_BR | C_AB,        4'd6, 10'd7, 1, 0, 0);
    step("stall_br",   C_SL | C_BR | C_AB, 4'd2, 10'd7, 1, 0, 0);
    step("halt_stall", C_HL | C_SL,        4'd0, 10'd7, 0, 1, 0);
    step("halt_ign",   C_BR | C_AB,        4'd2, 10'd7, 0, 1, 0);
    step("restart",    C_ST,               4'd0, 10'd0, 1, 0, 0);

`ifdef PC_CALL_STACK_EN
    // 5. call / return
    step("abs_5",      C_BR | C_AB, 4'd7, 10'd5,  1, 0, 0);
    step("call_abs",   C_CL | C_AB, 4'd1, 10'd10, 1, 0, 0);
    step("ret",        C_RT,        4'd0, 10'd6,  1, 0, 0);
    step("call1",      C_CL,        4'd1, 10'd16, 1, 0, 0);
    step("call2",      C_CL,        4'd1, 10'd26, 1, 0, 0);
    step("call3",      C_CL,        4'd1, 10'd36, 1, 0, 0);
    step("call4",      C_CL,        4'd1, 10'd46, 1, 0, 0);
    step("call5_ovf",  C_CL,        4'd1, 10'd56, 1, 0, 1);
    step("ret4",       C_RT | C_CL, 4'd1, 10'd37, 1, 0, 1);
    step("ret3",       C_RT,        4'd0, 10'd27, 1, 0, 1);
    step("ret2",       C_RT,        4'd0, 10'd17, 1, 0, 1);
    step("ret1",       C_RT,        4'd0, 10'd7,  1, 0, 1);
    step("ret_empty",  C_RT,        4'd0, 10'd8,  1, 0, 1);
`else
    // 5. without the stack: ret ignored, call acts as branch
    step("ret_ign",    C_RT,        4'd0, 10'd1,  1, 0, 0);
    step("call_as_br", C_CL | C_AB, 4'd1, 10'd10, 1, 0, 0);
    step("ret_inc",    C_RT,        4'd0, 10'd11, 1, 0, 0);
`endif

    // 6. reset mid-run
    step("abs_43b",    C_BR | C_AB, 4'd2, 10'd43, 1, 0,
`ifdef PC_CALL_STACK_EN
         1
`else
         0
`endif
    );
    do_reset("reset_run");
    step("idle_after", C_RT | C_BR, 4'd1, 10'd0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
